pipe_ctrl: RTL and testbench



---
 rtl/pipe_ctrl_pkg.sv | 31 +++
 rtl/pipe_ctrl_perf_cnt.sv | 35 +++
 rtl/pipe_ctrl.sv | 124 ++++++++++++
 tb/tb_pipe_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared core pipeline definitions: stage index type, default stage names and flush request bundle.
package cpu_defs;

   localparam int MAX_STAGE_NUM = 16;
   localparam int MAX_IDX_W     = $clog2(MAX_STAGE_NUM + 1);
   localparam int BUBBLE_W      = 4;
   localparam int PERF_W        = 32;

   typedef logic [MAX_IDX_W-1:0] stage_idx_t;

   typedef enum logic [2:0] {
      STG_IF1 = 3'd0,
      STG_IF2 = 3'd1,
      STG_ID  = 3'd2,
      STG_RR  = 3'd3,
      STG_EX  = 3'd4,
      STG_MEM = 3'd5,
      STG_WB  = 3'd6
   } pipe_stage_e;

   typedef struct packed {
      logic       req;
      stage_idx_t stage;
   } flush_req_t;

   // Boundaries past the last stage mean "kill everything".
   function automatic stage_idx_t sat_stage(input stage_idx_t v, input int n);
      return (int'(v) > n) ? stage_idx_t'(n) : v;
   endfunction

endpackage

// File: rtl/pipe_ctrl_perf_cnt.sv
// Per-stage saturating stall counters with a registered-array read mux (built only with PIPE_PERF_EN).
module pipe_perf_cnt
   import cpu_defs::*;
#(
   parameter int STAGE_NUM = 7,
   parameter int IDX_W     = $clog2(STAGE_NUM + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [STAGE_NUM-1:0] inc,
   input  logic [IDX_W-1:0]     sel,
   output logic [PERF_W-1:0]    data
);

   logic [STAGE_NUM-1:0][PERF_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else begin
         for (int i = 0; i < STAGE_NUM; i++) begin
            if (inc[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + PERF_W'(1);
         end
      end
   end

   // Out-of-range selects read as zero.
   always_comb begin
      data = '0;
      for (int i = 0; i < STAGE_NUM; i++) begin
         if (sel == IDX_W'(i)) data = cnt[i];
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stage valids, backpressure ready/advance chain, merged flushes, redirect bubble, commit count.
// Optional stall counters are compiled in when PIPE_PERF_EN is defined.
module pipe_ctrl
   import cpu_defs::*;
#(
   parameter int STAGE_NUM       = 7,
   parameter int FLUSH_SRC_NUM   = 2,
   parameter int REDIRECT_BUBBLE = 1,
   parameter int IDX_W           = $clog2(STAGE_NUM + 1)
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                issue_valid,
   output logic                                issue_rdy,
   input  logic [STAGE_NUM-1:0]                stage_busy,
   input  logic                                sink_rdy,
   input  logic [FLUSH_SRC_NUM-1:0]            flush_req,
   input  logic [FLUSH_SRC_NUM-1:0][IDX_W-1:0] flush_stage,
   output logic [STAGE_NUM-1:0]                stage_valid,
   output logic [STAGE_NUM-1:0]                rdy_in,
   output logic [STAGE_NUM-1:0]                adv,
   output logic                                commit,
   output logic [31:0]                         commit_cnt,
   input  logic [IDX_W-1:0]                    perf_sel,
   output logic [31:0]                         perf_data
);

   flush_req_t [FLUSH_SRC_NUM-1:0] flush_vec;
   stage_idx_t                     kill_f;
   logic [STAGE_NUM:0]             rdy_ext;
   logic [STAGE_NUM-1:0]           leave;
   logic [STAGE_NUM-1:0]           src;
   logic [STAGE_NUM-1:0]           valid_nxt;
   logic [BUBBLE_W-1:0]            bubble_cnt;

   always_comb begin
      for (int s = 0; s < FLUSH_SRC_NUM; s++) begin
         flush_vec[s].req   = flush_req[s];
         flush_vec[s].stage = stage_idx_t'(flush_stage[s]);
      end
   end

   // Oldest boundary among active sources wins.
   always_comb begin
      kill_f = '0;
      for (int s = 0; s < FLUSH_SRC_NUM; s++) begin
         if (flush_vec[s].req && (sat_stage(flush_vec[s].stage, STAGE_NUM) > kill_f))
            kill_f = sat_stage(flush_vec[s].stage, STAGE_NUM);
      end
   end

   // Ready ripples from the sink back toward stage 0.
   always_comb begin
      rdy_ext            = '0;
      leave              = '0;
      rdy_ext[STAGE_NUM] = sink_rdy;
      for (int i = STAGE_NUM - 1; i >= 0; i--) begin
         leave[i]   = stage_valid[i] & ~stage_busy[i] & rdy_ext[i+1];
         rdy_ext[i] = ~stage_valid[i] | leave[i];
      end
   end

   // A stage only loads when its predecessor survives the flush (index >= F).
   always_comb begin
      src    = '0;
      src[0] = issue_valid & (bubble_cnt == '0) & (kill_f == '0);
      for (int i = 1; i < STAGE_NUM; i++) begin
         src[i] = stage_valid[i-1] & ~stage_busy[i-1] & (stage_idx_t'(i) > kill_f);
      end
   end

   assign rdy_in    = rdy_ext[STAGE_NUM-1:0];
   assign adv       = rdy_in & src;
   assign issue_rdy = adv[0];
   assign commit    = leave[STAGE_NUM-1];

   always_comb begin
      valid_nxt = '0;
      for (int i = 0; i < STAGE_NUM; i++) begin
         if (stage_idx_t'(i) < kill_f) valid_nxt[i] = 1'b0;
         else                          valid_nxt[i] = adv[i] | (stage_valid[i] & ~leave[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_valid <= '0;
         bubble_cnt  <= '0;
         commit_cnt  <= '0;
      end else begin
         stage_valid <= valid_nxt;
         if (kill_f != '0)           bubble_cnt <= BUBBLE_W'(REDIRECT_BUBBLE);
         else if (bubble_cnt != '0)  bubble_cnt <= bubble_cnt - BUBBLE_W'(1);
         if (commit)                 commit_cnt <= commit_cnt + 32'd1;
      end
   end

`ifdef PIPE_PERF_EN
   logic [STAGE_NUM-1:0] stall_inc;

   always_comb begin
      stall_inc = '0;
      for (int i = 0; i < STAGE_NUM; i++) begin
         stall_inc[i] = stage_valid[i] & ~leave[i] & (stage_idx_t'(i) >= kill_f);
      end
   end

   pipe_perf_cnt #(
      .STAGE_NUM (STAGE_NUM),
      .IDX_W     (IDX_W)
   ) u_perf (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (stall_inc),
      .sel   (perf_sel),
      .data  (perf_data)
   );
`else
   logic unused_perf_sel;
   assign unused_perf_sel = ^perf_sel;
   assign perf_data       = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed plus randomized bench for pipe_ctrl against a token-level pipeline model.
module tb_pipe_ctrl;

   localparam int N  = 7;
   localparam int NF = 2;
   localparam int RB = 1;
   localparam int IW = 3;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic                    issue_valid;
   logic                    issue_rdy;
   logic [N-1:0]            stage_busy;
   logic                    sink_rdy;
   logic [NF-1:0]           flush_req;
   logic [NF-1:0][IW-1:0]   flush_stage;
   logic [N-1:0]            stage_valid;
   logic [N-1:0]            rdy_in;
   logic [N-1:0]            adv;
   logic                    commit;
   logic [31:0]             commit_cnt;
   logic [IW-1:0]           perf_sel;
   logic [31:0]             perf_data;

   pipe_ctrl #(
      .STAGE_NUM       (N),
      .FLUSH_SRC_NUM   (NF),
      .REDIRECT_BUBBLE (RB),
      .IDX_W           (IW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .issue_valid (issue_valid),
      .issue_rdy   (issue_rdy),
      .stage_busy  (stage_busy),
      .sink_rdy    (sink_rdy),
      .flush_req   (flush_req),
      .flush_stage (flush_stage),
      .stage_valid (stage_valid),
      .rdy_in      (rdy_in),
      .adv         (adv),
      .commit      (commit),
      .commit_cnt  (commit_cnt),
      .perf_sel    (perf_sel),
      .perf_data   (perf_data)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: each slot holds an instruction id or -1 when empty.
   int          slot[N];
   int          nslot[N];
   bit          mv[N];
   int          next_id;
   int          bubble;
   int          fb;
   logic [31:0] m_cnt;
   logic [31:0] m_stall[N];
   logic [N-1:0] e_rdy;
   logic [N-1:0] e_adv;
   logic         e_commit;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         slot[i]    = -1;
         m_stall[i] = '0;
      end
      next_id = 0;
      bubble  = 0;
      m_cnt   = '0;
   endtask

   function automatic logic [N-1:0] exp_valid();
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) v[i] = (slot[i] >= 0);
      return v;
   endfunction

   task automatic model_eval();
      bit out_ok;
      fb = 0;
      for (int s = 0; s < NF; s++) begin
         if (flush_req[s]) begin
            int v;
            v = int'(flush_stage[s]);
            if (v > N) v = N;
            if (v > fb) fb = v;
         end
      end
      for (int i = N - 1; i >= 0; i--) begin
         out_ok   = (i == N - 1) ? sink_rdy : ((slot[i+1] < 0) || mv[i+1]);
         mv[i]    = (slot[i] >= 0) && !stage_busy[i] && out_ok;
         e_rdy[i] = (slot[i] < 0) || mv[i];
      end
      e_adv = '0;
      for (int i = 0; i < N; i++) nslot[i] = (slot[i] >= 0 && !mv[i]) ? slot[i] : -1;
      for (int i = 0; i < N - 1; i++) begin
         if (mv[i] && (i + 1 > fb)) begin
            nslot[i+1]  = slot[i];
            e_adv[i+1] = 1'b1;
         end
      end
      if (e_rdy[0] && issue_valid && bubble == 0 && fb == 0) begin
         nslot[0] = next_id;
         e_adv[0] = 1'b1;
      end
      e_commit = mv[N-1];
   endtask

   task automatic model_commit();
      for (int i = 0; i < N; i++) begin
         if (slot[i] >= 0 && !mv[i] && i >= fb && m_stall[i] != '1) m_stall[i] = m_stall[i] + 1;
      end
      for (int i = 0; i < N; i++) slot[i] = (i < fb) ? -1 : nslot[i];
      if (e_adv[0]) next_id++;
      if (e_commit) m_cnt = m_cnt + 1;
      if (fb > 0)          bubble = RB;
      else if (bubble > 0) bubble = bubble - 1;
   endtask

   // Called at posedge+1 with inputs already applied; returns at the next posedge+1.
   task automatic step(input string tag);
      model_eval();
      @(negedge clk);
      chk({tag, "/rdy_in"}, 64'(rdy_in), 64'(e_rdy));
      chk({tag, "/adv"}, 64'(adv), 64'(e_adv));
      chk({tag, "/issue_rdy"}, 64'(issue_rdy), 64'(e_adv[0]));
      chk({tag, "/commit"}, 64'(commit), 64'(e_commit));
      @(posedge clk);
      model_commit();
      #1;
      chk({tag, "/stage_valid"}, 64'(stage_valid), 64'(exp_valid()));
      chk({tag, "/commit_cnt"}, 64'(commit_cnt), 64'(m_cnt));
`ifdef PIPE_PERF_EN
      chk({tag, "/perf_data"}, 64'(perf_data),
          64'((int'(perf_sel) < N) ? m_stall[perf_sel] : 32'd0));
`endif
   endtask

   task automatic idle();
      issue_valid = 1'b1;
      stage_busy  = '0;
      sink_rdy    = 1'b1;
      flush_req   = '0;
      flush_stage = '0;
      perf_sel    = IW'(6);
   endtask

   task automatic sync_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      idle();
      model_reset();
      #12;
      chk("reset/stage_valid", 64'(stage_valid), 64'd0);
      chk("reset/commit_cnt", 64'(commit_cnt), 64'd0);
      chk("reset/rdy_in", 64'(rdy_in), 64'({N{1'b1}}));
      chk("reset/commit", 64'(commit), 64'd0);
      chk("reset/perf_data", 64'(perf_data), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Streaming issue with no stalls.
      for (int c = 0; c < 16; c++) step("stream");

      // Mid-pipe stall at stage 3.
      stage_busy[3] = 1'b1;
      for (int c = 0; c < 3; c++) step("busy3");
      stage_busy = '0;
      for (int c = 0; c < 6; c++) step("busy3_drain");

      // Single flush at boundary 3.
      for (int c = 0; c < 8; c++) step("fill_a");
      flush_req[0] = 1'b1;
      flush_stage[0] = IW'(3);
      step("flush3");
      chk("flush3/kill", 64'(stage_valid[2:0]), 64'd0);
      idle();
      for (int c = 0; c < 4; c++) step("flush3_after");

      // Two flushes in one cycle: the older boundary wins.
      for (int c = 0; c < 8; c++) step("fill_b");
      flush_req = 2'b11;
      flush_stage[0] = IW'(3);
      flush_stage[1] = IW'(5);
      step("flush35");
      chk("flush35/kill", 64'(stage_valid[4:0]), 64'd0);
      idle();
      for (int c = 0; c < 4; c++) step("flush35_after");

      // Sink backpressure on a full pipe, from a clean reset.
      sync_reset();
      for (int c = 0; c < 7; c++) step("fill_c");
      sink_rdy = 1'b0;
      for (int c = 0; c < 5; c++) step("sink_hold");
      chk("sink_hold/rdy_in", 64'(rdy_in), 64'd0);
`ifdef PIPE_PERF_EN
      chk("sink_hold/perf6", 64'(perf_data), 64'd5);
`endif
      idle();
      for (int c = 0; c < 3; c++) step("sink_release");

      // Randomized traffic.
      for (int c = 0; c < 400; c++) begin
         issue_valid = ($urandom_range(3) != 0);
         for (int i = 0; i < N; i++) stage_busy[i] = ($urandom_range(7) == 0);
         sink_rdy = ($urandom_range(3) != 0);
         for (int s = 0; s < NF; s++) begin
            flush_req[s]   = ($urandom_range(15) == 0);
            flush_stage[s] = IW'($urandom_range(7));
         end
         perf_sel = IW'($urandom_range(7));
         step("rand");
      end

      // Asynchronous reset away from any clock edge.
      idle();
      for (int c = 0; c < 12; c++) step("pre_async");
      #3;
      rst_n = 1'b0;
      #1;
      chk("async/stage_valid", 64'(stage_valid), 64'd0);
      chk("async/commit_cnt", 64'(commit_cnt), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      for (int c = 0; c < 10; c++) step("post_async");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
